fifo_param_flow: RTL and testbench
==================================

// Module: fifo_param_flow
// PURPOSE
//  Parametrised synchronous FIFO: next generation of the 6-bit/8-deep datapath FIFO.
//  Adds generic width/depth, a fill-level output, a hysteretic pause flow-control
//  output, and sticky overflow/underflow error flags with a clear input.
//  Sits between a producer and a consumer in one clock domain; pause throttles the producer.
// PARAMETERS
//  DATA_W   6   data word width in bits
//  ADDR_W   3   pointer width; DEPTH = 2**ADDR_W entries (default 8)
// PORTS
//  clk            in   1         rising-edge clock
//  RESET          in   1         asynchronous reset, active-high
//  data_in        in   DATA_W    write data
//  fifo_wr        in   1         write request
//  fifo_rd        in   1         read request
//  al_empty_in    in   ADDR_W+1  almost-empty threshold (entries)
//  al_full_in     in   ADDR_W+1  almost-full threshold (entries)
//  err_clr        in   1         synchronous clear of sticky error flags
//  data_out       out  DATA_W    registered read data
//  valid_out      out  1         data_out carries a newly popped word this cycle
//  fifo_empty     out  1         count == 0
//  fifo_full      out  1         count == DEPTH
//  al_empty       out  1         count <= al_empty_in
//  al_full        out  1         count >= al_full_in
//  pause          out  1         registered hysteretic back-pressure to the producer
//  fill_level     out  ADDR_W+1  current count
//  err_overflow   out  1         sticky: write refused because FIFO was full
//  err_underflow  out  1         sticky: read refused because FIFO was empty
// BEHAVIOUR
//  - Reset (async, RESET=1): wr_ptr, rd_ptr, count, data_out, valid_out, pause,
//    err_* all 0; so fifo_empty=1, al_empty=1, others 0. Memory not cleared.
//    Reset mid-operation discards all stored words.
//  - rd_ok = fifo_rd & !fifo_empty. wr_ok = fifo_wr & (!fifo_full | rd_ok).
//  - On rd_ok: data_out <= mem[rd_ptr], rd_ptr++, valid_out=1 next cycle (1-cycle latency).
//    Without rd_ok: valid_out=0, data_out holds its last value.
//  - On wr_ok: mem[wr_ptr] <= data_in, wr_ptr++.
//  - Pointers wrap modulo DEPTH naturally (ADDR_W bits). count += wr_ok - rd_ok.
//  - Simultaneous wr+rd when full: both accepted, count stays DEPTH, no overflow.
//  - Simultaneous wr+rd when empty: write accepted, read refused (no fall-through),
//    err_underflow set, valid_out=0 next cycle, count becomes 1.
//  - err_overflow set when fifo_wr & !wr_ok; err_underflow set when fifo_rd & fifo_empty.
//    Both sticky; err_clr clears them, but a new error in the same cycle wins (stays 1).
//  - fifo_empty, fifo_full, al_empty, al_full, fill_level: combinational from current
//    count and live thresholds (no extra latency).
//  - pause FSM, two states RUN/PAUSE, registered, evaluated on next-count:
//    RUN -> PAUSE when next_count >= al_full_in;
//    PAUSE -> RUN when next_count <= al_empty_in; set has priority if both hold.
//    pause = (state == PAUSE). Thresholds with al_empty_in >= al_full_in are legal;
//    set priority makes pause stick at 1 while next_count >= al_full_in.
//  - Refused operations change no pointer, count or memory state.
// TESTING (DATA_W=6, ADDR_W=3, al_empty_in=2, al_full_in=6)
//  1 Reset then write 6'b010010, read next cycle -> data_out=6'b010010, valid_out=1
//    one cycle after read, fifo_empty=1 after, no error flags.
//  2 Write 8 words 0..7 -> fifo_full=1, fill_level=8, al_full from count 6; 9th write
//    -> err_overflow=1, count stays 8; read all -> data_out 0..7 in order.
//  3 Hysteresis: fill to 6 -> pause=1 the cycle after count reaches 6; drain to 3
//    -> pause still 1; drain to 2 -> pause=0 next cycle.
//  4 Full + simultaneous wr/rd for 4 cycles -> count stays 8, no overflow, output
//    order preserved across pointer wrap (writes 8..11 read back after 0..7).
//  5 Empty + fifo_rd with fifo_wr -> err_underflow=1, valid_out=0, count=1;
//    assert err_clr -> err_underflow=0 next cycle.
//  6 Assert RESET mid-burst with count=5 -> immediately fifo_empty=1, pause=0,
//    valid_out=0; subsequent write/read returns only post-reset data.

Source files
------------

// File: rtl/fifo_param_flow_if.sv
// Producer/consumer bundle for fifo_param_flow: write/read requests, thresholds,
// error clear, and all status outputs of the FIFO.
interface fifo_param_flow_if #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0] data_in;
    logic              fifo_wr;
    logic              fifo_rd;
    logic [ADDR_W:0]   al_empty_in;
    logic [ADDR_W:0]   al_full_in;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              fifo_empty;
    logic              fifo_full;
    logic              al_empty;
    logic              al_full;
    logic              pause;
    logic [ADDR_W:0]   fill_level;
    logic              err_overflow;
    logic              err_underflow;

    modport master (
        output data_in, fifo_wr, fifo_rd, al_empty_in, al_full_in, err_clr,
        input  data_out, valid_out, fifo_empty, fifo_full, al_empty, al_full,
               pause, fill_level, err_overflow, err_underflow
    );

    modport slave (
        input  data_in, fifo_wr, fifo_rd, al_empty_in, al_full_in, err_clr,
        output data_out, valid_out, fifo_empty, fifo_full, al_empty, al_full,
               pause, fill_level, err_overflow, err_underflow
    );
endinterface

// File: rtl/fifo_param_flow.sv
// Parametrised single-clock FIFO with fill level, hysteretic pause back-pressure
// and sticky overflow/underflow flags.
//
//  state | meaning
//  RUN   | producer may write freely, pause = 0
//  PAUSE | fill crossed al_full_in; held until fill drops to al_empty_in
module fifo_param_flow #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 3
) (
    input logic               clk,
    input logic               RESET,
    fifo_param_flow_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [0:0]      RUN       = 1'b0;
    localparam logic [0:0]      PAUSE     = 1'b1;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count, next_count;
    logic [0:0]        state, state_nxt;
    logic              rd_ok, wr_ok;
    logic              empty_now, full_now;

    assign empty_now = (count == '0);
    assign full_now  = (count == DEPTH_CNT);

    // A read frees a slot in the same cycle, so a full FIFO can still accept a write
    assign rd_ok = bus.fifo_rd & ~empty_now;
    assign wr_ok = bus.fifo_wr & (~full_now | rd_ok);

    assign next_count = count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);

    always_comb begin
        state_nxt = state;
        if (next_count >= bus.al_full_in)
            state_nxt = PAUSE;
        else if (next_count <= bus.al_empty_in)
            state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            state             <= RUN;
            bus.data_out      <= '0;
            bus.valid_out     <= 1'b0;
            bus.err_overflow  <= 1'b0;
            bus.err_underflow <= 1'b0;
        end else begin
            count         <= next_count;
            state         <= state_nxt;
            bus.valid_out <= rd_ok;
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr       <= rd_ptr + 1'b1;
                bus.data_out <= mem[rd_ptr];
            end
            // A fresh error in the clearing cycle keeps the flag set
            bus.err_overflow  <= (bus.fifo_wr & ~wr_ok) | (bus.err_overflow & ~bus.err_clr);
            bus.err_underflow <= (bus.fifo_rd & empty_now) | (bus.err_underflow & ~bus.err_clr);
        end
    end

    assign bus.fifo_empty = empty_now;
    assign bus.fifo_full  = full_now;
    assign bus.al_empty   = (count <= bus.al_empty_in);
    assign bus.al_full    = (count >= bus.al_full_in);
    assign bus.fill_level = count;
    assign bus.pause      = (state == PAUSE);
endmodule

// File: tb/tb_fifo_param_flow.sv
// Self-checking bench for fifo_param_flow: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_fifo_param_flow;
    logic clk = 1'b0;
    logic RESET = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fifo_param_flow_if #(.DATA_W(6), .ADDR_W(3)) bus ();

    fifo_param_flow #(.DATA_W(6), .ADDR_W(3)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference model
    int       q[$];
    logic [5:0] m_dout;
    logic     m_valid, m_pause, m_ovf, m_unf;

    task automatic model_reset();
        q.delete();
        m_dout = '0; m_valid = 0; m_pause = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic step(input logic wr, input logic rd, input logic [5:0] din, input logic clr);
        bit empty, full, rd_ok, wr_ok;
        int n;
        bus.fifo_wr = wr; bus.fifo_rd = rd; bus.data_in = din; bus.err_clr = clr;
        empty = (q.size() == 0);
        full  = (q.size() == 8);
        rd_ok = rd && !empty;
        wr_ok = wr && (!full || rd_ok);
        if (rd_ok) m_dout = 6'(q.pop_front());
        m_valid = rd_ok;
        if (wr_ok) q.push_back(int'(din));
        m_ovf = (wr && !wr_ok) || (m_ovf && !clr);
        m_unf = (rd && empty) || (m_unf && !clr);
        n = q.size();
        if (n >= int'(bus.al_full_in)) m_pause = 1;
        else if (n <= int'(bus.al_empty_in)) m_pause = 0;
        @(posedge clk);
        #1;
        bus.fifo_wr = 0; bus.fifo_rd = 0; bus.err_clr = 0;
    endtask

    task automatic do_reset();
        bus.fifo_wr = 0; bus.fifo_rd = 0; bus.err_clr = 0;
        #2 RESET = 1;
        #1 RESET = 0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1;
        bus.fifo_wr = 0; bus.fifo_rd = 0; bus.err_clr = 0; bus.data_in = '0;
        bus.al_empty_in = 4'd2; bus.al_full_in = 4'd6;
        #3;
        checks++;
        if ({bus.fifo_empty, bus.al_empty, bus.fifo_full, bus.al_full, bus.pause,
             bus.valid_out, bus.err_overflow, bus.err_underflow} !== 8'b1100_0000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=11000000", {bus.fifo_empty, bus.al_empty,
                bus.fifo_full, bus.al_full, bus.pause, bus.valid_out, bus.err_overflow, bus.err_underflow});
        end
        checks++;
        if (bus.fill_level !== 4'd0 || bus.data_out !== 6'd0) begin
            errors++;
            $display("FAIL reset_level got=%0d/%0d want=0/0", bus.fill_level, bus.data_out);
        end
        RESET = 0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        step(1, 0, 6'b010010, 0);
        checks++;
        if (bus.fill_level !== 4'd1 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_write got=lvl%0d v%b want=lvl1 v0", bus.fill_level, bus.valid_out);
        end
        step(0, 1, 6'd0, 0);
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 6'b010010 || bus.fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL single_read got=v%b d%b e%b want=v1 d010010 e1",
                     bus.valid_out, bus.data_out, bus.fifo_empty);
        end
        checks++;
        if (bus.err_overflow !== 1'b0 || bus.err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL single_err got=%b%b want=00", bus.err_overflow, bus.err_underflow);
        end
        step(0, 0, 6'd0, 0);
        checks++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 6'b010010) begin
            errors++;
            $display("FAIL single_hold got=v%b d%b want=v0 d010010", bus.valid_out, bus.data_out);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 6'(i), 0);
            checks++;
            if (bus.fill_level !== 4'(i + 1) || bus.al_full !== (i + 1 >= 6)) begin
                errors++;
                $display("FAIL fill_%0d got=lvl%0d af%b want=lvl%0d af%b", i, bus.fill_level,
                         bus.al_full, i + 1, (i + 1 >= 6));
            end
        end
        checks++;
        if (bus.fifo_full !== 1'b1 || bus.err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_flag got=f%b ovf%b want=f1 ovf0", bus.fifo_full, bus.err_overflow);
        end
        step(1, 0, 6'd63, 0);
        checks++;
        if (bus.err_overflow !== 1'b1 || bus.fill_level !== 4'd8) begin
            errors++;
            $display("FAIL overflow got=ovf%b lvl%0d want=ovf1 lvl8", bus.err_overflow, bus.fill_level);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 6'd0, 0);
            checks++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== 6'(i)) begin
                errors++;
                $display("FAIL drain_%0d got=v%b d%0d want=v1 d%0d", i, bus.valid_out, bus.data_out, i);
            end
        end
        step(0, 0, 6'd0, 1);
        checks++;
        if (bus.err_overflow !== 1'b0 || bus.fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear got=ovf%b e%b want=ovf0 e1", bus.err_overflow, bus.fifo_empty);
        end
    endtask

    task automatic test_hysteresis();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 6'(i + 20), 0);
            checks++;
            if (bus.pause !== (i == 5)) begin
                errors++;
                $display("FAIL hyst_fill_%0d got=%b want=%b", i + 1, bus.pause, (i == 5));
            end
        end
        for (int i = 5; i >= 2; i--) begin
            step(0, 1, 6'd0, 0);
            checks++;
            if (bus.pause !== (i > 2) || bus.fill_level !== 4'(i)) begin
                errors++;
                $display("FAIL hyst_drain_%0d got=p%b lvl%0d want=p%b lvl%0d", i, bus.pause,
                         bus.fill_level, (i > 2), i);
            end
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 6'(i), 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 6'(8 + i), 0);
            checks++;
            if (bus.fill_level !== 4'd8 || bus.err_overflow !== 1'b0 || bus.data_out !== 6'(i)
                || bus.valid_out !== 1'b1) begin
                errors++;
                $display("FAIL wrap_rw_%0d got=lvl%0d ovf%b d%0d v%b want=lvl8 ovf0 d%0d v1", i,
                         bus.fill_level, bus.err_overflow, bus.data_out, bus.valid_out, i);
            end
        end
        for (int i = 4; i < 12; i++) begin
            step(0, 1, 6'd0, 0);
            checks++;
            if (bus.data_out !== 6'(i)) begin
                errors++;
                $display("FAIL wrap_drain got=%0d want=%0d", bus.data_out, i);
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1, 1, 6'd33, 0);
        checks++;
        if (bus.err_underflow !== 1'b1 || bus.valid_out !== 1'b0 || bus.fill_level !== 4'd1) begin
            errors++;
            $display("FAIL underflow got=unf%b v%b lvl%0d want=unf1 v0 lvl1",
                     bus.err_underflow, bus.valid_out, bus.fill_level);
        end
        step(0, 0, 6'd0, 1);
        checks++;
        if (bus.err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL unf_clear got=%b want=0", bus.err_underflow);
        end
        step(0, 1, 6'd0, 0);
        step(0, 1, 6'd0, 1);
        checks++;
        if (bus.err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_clr_race got=%b want=1", bus.err_underflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 6'(40 + i), 0);
        step(0, 1, 6'd0, 0);
        checks++;
        if (bus.fill_level !== 4'd5 || bus.pause !== 1'b1 || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got=lvl%0d p%b v%b want=lvl5 p1 v1",
                     bus.fill_level, bus.pause, bus.valid_out);
        end
        #2 RESET = 1;
        #1;
        checks++;
        if (bus.fifo_empty !== 1'b1 || bus.pause !== 1'b0 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got=e%b p%b v%b want=e1 p0 v0",
                     bus.fifo_empty, bus.pause, bus.valid_out);
        end
        RESET = 0;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 6'd17, 0);
        step(0, 1, 6'd0, 0);
        checks++;
        if (bus.data_out !== 6'd17 || bus.fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got=d%0d e%b want=d17 e1", bus.data_out, bus.fifo_empty);
        end
    endtask

    task automatic test_random();
        logic [13:0] got, exp;
        int n, wp, rp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 75 == 0) begin
                bus.al_empty_in = 4'($urandom_range(0, 8));
                bus.al_full_in  = 4'($urandom_range(0, 8));
                wp = $urandom_range(20, 90);
                rp = $urandom_range(20, 90);
            end
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 6'($urandom),
                 $urandom_range(0, 9) == 0);
            n = q.size();
            got = {bus.fill_level, bus.fifo_empty, bus.fifo_full, bus.al_empty, bus.al_full,
                   bus.pause, bus.valid_out, bus.err_overflow, bus.err_underflow, 2'b00};
            exp = {4'(n), n == 0, n == 8, n <= int'(bus.al_empty_in), n >= int'(bus.al_full_in),
                   m_pause, m_valid, m_ovf, m_unf, 2'b00};
            checks++;
            if (got !== exp || bus.data_out !== m_dout) begin
                errors++;
                $display("FAIL random_c%0d got=%b d%0d want=%b d%0d", c, got, bus.data_out, exp, m_dout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_hysteresis();
        test_full_wrap();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
